// File: rtl/mc_control_unit.sv
// Multi-cycle sequencer for the 8-bit four-register core: fetches one
// instruction byte over req/ack, then walks it through DECODE/EXEC/MEM/WB,
// raising each datapath strobe only in the cycle that needs it.
module mc_control_unit #(
    parameter int unsigned IMEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [7:0]       imem_data,
    output logic [7:0]       ir,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = $clog2(IMEM_WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_STORE  = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    state_t            state_q;
    state_t            state_d;
    state_t            retire_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              step_prev;
    logic              step_pending;
    logic              step_edge;
    logic              fetch_timeout;
    logic              retire;
    logic [1:0]        opcode;

    assign opcode        = ir[7:6];
    assign step_edge     = step & ~step_prev;
    assign retire_state  = run ? S_FETCH : S_IDLE;
    // The last permitted waiting cycle: the counter reaches the limit here.
    assign fetch_timeout = (state_q == S_FETCH) && !imem_ack
                           && (wait_cnt == WAIT_W'(IMEM_WAIT_MAX - 1));
    assign state         = state_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; retiring states return to FETCH or IDLE depending on run
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run || step_pending) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack)           state_d = S_DECODE;
                else if (fetch_timeout) state_d = S_FAULT;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_BRANCH)   state_d = retire_state;
                else if (opcode == OP_ADD) state_d = S_WB;
                else                       state_d = S_MEM;
            end
            S_MEM:    state_d = (opcode == OP_LOAD) ? S_WB : retire_state;
            S_WB:     state_d = retire_state;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state (ir_write also qualified by imem_ack)
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ack;
            end
            S_DECODE: begin
                reg_dst    = ~ir[6];
                alu_src    = ir[7] ^ ir[6];
                mem_to_reg = ir[6];
            end
            S_EXEC: begin
                reg_dst    = ~ir[6];
                alu_src    = ir[7] ^ ir[6];
                mem_to_reg = ir[6];
                if (opcode == OP_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                    retire   = 1'b1;
                end
            end
            S_MEM: begin
                reg_dst    = ~ir[6];
                alu_src    = ir[7] ^ ir[6];
                mem_to_reg = ir[6];
                if (opcode == OP_LOAD) begin
                    mem_read = 1'b1;
                end else if (opcode == OP_STORE) begin
                    mem_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                end
            end
            S_WB: begin
                reg_dst    = ~ir[6];
                alu_src    = ir[7] ^ ir[6];
                mem_to_reg = ir[6];
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                mem_read   = (opcode == OP_LOAD);
            end
            default: ;
        endcase
    end

    // Instruction register, fetch wait counter and sticky fault flag
    always_ff @(posedge clock) begin
        if (reset) begin
            ir       <= '0;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else if (state_q == S_FETCH) begin
            if (imem_ack) begin
                ir       <= imem_data;
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
                if (fetch_timeout) fault <= 1'b1;
            end
        end
    end

    // Single-step edge capture; a new request wins over the consuming transition
    always_ff @(posedge clock) begin
        if (reset) begin
            step_prev    <= 1'b0;
            step_pending <= 1'b0;
        end else begin
            step_prev <= step;
            if (step_edge && !run)
                step_pending <= 1'b1;
            else if (state_q == S_IDLE && (run || step_pending))
                step_pending <= 1'b0;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clock) begin
        if (reset)       instr_count <= '0;
        else if (retire) instr_count <= instr_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: the driver pushes the expected
// per-instruction behaviour when it acks a fetch, the monitor pops it when
// the instruction retires (pc_write) and compares.
module tb_mc_control_unit;

    localparam int unsigned CW       = 4;
    localparam int unsigned WAIT_MAX = 15;
    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_FETCH = 3'd1;
    localparam logic [2:0]  ST_MEM   = 3'd4;
    localparam logic [2:0]  ST_FAULT = 3'd7;

    logic          clock, reset, run, step;
    logic          imem_req, imem_ack;
    logic [7:0]    imem_data, ir;
    logic          ir_write, pc_write, pc_src, reg_write, reg_dst, alu_src;
    logic          mem_read, mem_write, mem_to_reg, fault;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    mc_control_unit #(.IMEM_WAIT_MAX(WAIT_MAX), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .run(run), .step(step),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(ir), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .state(state), .fault(fault), .instr_count(instr_count)
    );

    typedef struct {
        logic [7:0]    ir;
        int            lat;
        int            rw;
        int            mr;
        int            mw;
        logic          psrc;
        logic          asrc;
        logic          rdst;
        logic          m2r;
        logic [2:0]    nx;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] model_cnt;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected behaviour of one instruction, straight from the opcode table
    function automatic exp_t model(input logic [7:0] d, input logic [2:0] nx,
                                   input logic [CW-1:0] cnt);
        exp_t e;
        e.ir = d; e.nx = nx; e.cnt = cnt;
        e.rw = 0; e.mr = 0; e.mw = 0;
        e.psrc = 1'b0; e.asrc = 1'b0; e.rdst = 1'b0; e.m2r = 1'b0;
        case (d[7:6])
            2'b00:   begin e.lat = 3; e.rw = 1; e.rdst = 1'b1; end
            2'b01:   begin e.lat = 4; e.rw = 1; e.mr = 2; e.asrc = 1'b1; e.m2r = 1'b1; end
            2'b10:   begin e.lat = 3; e.mw = 1; e.asrc = 1'b1; end
            default: begin e.lat = 2; e.psrc = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic wait_state(input logic [2:0] s, input int lim);
        int n = 0;
        while (state !== s && n < lim) begin
            @(posedge clock); #1; n++;
        end
        chk("wait_state", 32'(state), 32'(s));
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(posedge clock); #1;
        step = 1'b0;
        @(posedge clock); #1;
    endtask

    // Wait for imem_req (spraying ignored acks meanwhile), ack after dly cycles
    task automatic fetch(input logic [7:0] d, input int dly, input bit drop, input bit push);
        int n = 0;
        logic [2:0] nx;
        while (imem_req !== 1'b1 && n < 50) begin
            imem_ack  = 1'($urandom_range(0, 1));
            imem_data = 8'($urandom);
            @(posedge clock); #1; n++;
        end
        imem_ack = 1'b0;
        chk("fetch_req", 32'(imem_req), 32'd1);
        if (imem_req !== 1'b1) return;
        repeat (dly) begin @(posedge clock); #1; end
        imem_ack  = 1'b1;
        imem_data = d;
        if (push) begin
            nx = (drop || !run) ? ST_IDLE : ST_FETCH;
            model_cnt = model_cnt + CW'(1);
            sb.push_back(model(d, nx, model_cnt));
        end
        @(posedge clock); #1;
        imem_ack  = 1'b0;
        imem_data = 8'($urandom);
        if (drop) begin
            run = 1'b0;
            wait_state(ST_IDLE, 20);
        end
    endtask

    // Monitor: trace strobes from the ack cycle to retire, then score
    int   cyc, n_rw, n_mr, n_mw;
    bit   active, chk_next;
    exp_t cur, nxt_e;
    logic s_rdst, s_m2r;
    always @(negedge clock) begin
        if (reset !== 1'b0) begin
            active   = 1'b0;
            chk_next = 1'b0;
        end else begin
            if (chk_next) begin
                chk("next_state", 32'(state), 32'(nxt_e.nx));
                chk("instr_count", 32'(instr_count), 32'(nxt_e.cnt));
                chk_next = 1'b0;
            end
            if (ir_write) begin
                chk("ack_overlap", 32'(active), 32'd0);
                chk("ir_write_req", 32'(imem_req), 32'd1);
                chk("quiet_at_ack", 32'({pc_write, pc_src, reg_write, reg_dst, alu_src,
                                         mem_read, mem_write, mem_to_reg}), 32'd0);
                active = 1'b1; cyc = 0; n_rw = 0; n_mr = 0; n_mw = 0;
                s_rdst = 1'b0; s_m2r = 1'b0;
            end else if (active) begin
                cyc++;
                if (reg_write) begin n_rw++; s_rdst = reg_dst; s_m2r = mem_to_reg; end
                if (mem_read)  n_mr++;
                if (mem_write) n_mw++;
                if (pc_write) begin
                    active = 1'b0;
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL sb_underflow: retire with no expected instruction at %0t", $time);
                    end else begin
                        cur = sb.pop_front();
                        chk("ir", 32'(ir), 32'(cur.ir));
                        chk("latency", 32'(cyc), 32'(cur.lat));
                        chk("pc_src", 32'(pc_src), 32'(cur.psrc));
                        chk("alu_src", 32'(alu_src), 32'(cur.asrc));
                        chk("reg_write_cnt", 32'(n_rw), 32'(cur.rw));
                        chk("mem_read_cnt", 32'(n_mr), 32'(cur.mr));
                        chk("mem_write_cnt", 32'(n_mw), 32'(cur.mw));
                        if (cur.rw != 0) begin
                            chk("reg_dst", 32'(s_rdst), 32'(cur.rdst));
                            chk("mem_to_reg", 32'(s_m2r), 32'(cur.m2r));
                        end
                        nxt_e    = cur;
                        chk_next = 1'b1;
                    end
                end else if (cyc >= 8) begin
                    total++; bad++;
                    $display("FAIL retire_timeout: no pc_write %0d cycles after ack", cyc);
                    active = 1'b0;
                end
            end else begin
                chk("idle_quiet", 32'({pc_write, pc_src, reg_write, reg_dst, alu_src,
                                       mem_read, mem_write, mem_to_reg}), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; run = 1'b0; step = 1'b0;
        imem_ack = 1'b0; imem_data = 8'h00; model_cnt = '0;
        repeat (2) @(posedge clock); #1;

        chk("reset_state", 32'(state), 32'(ST_IDLE));
        chk("reset_ir", 32'(ir), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_count", 32'(instr_count), 32'd0);
        chk("reset_strobes", 32'({imem_req, ir_write, pc_write, pc_src, reg_write, reg_dst,
                                  alu_src, mem_read, mem_write, mem_to_reg}), 32'd0);
        reset = 1'b0;
        run   = 1'b1;

        // Directed free-run: ADD, LOAD, STORE, BRANCH
        fetch(8'h1B, 0, 1'b0, 1'b1);
        fetch(8'h46, 0, 1'b0, 1'b1);
        fetch(8'h85, 1, 1'b0, 1'b1);
        fetch(8'hC3, 2, 1'b0, 1'b1);

        // Random free-run, stray step pulses while run=1, counter wraps
        for (int i = 0; i < 40; i++) begin
            fetch(8'($urandom), $urandom_range(0, 6), 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) pulse_step();
        end
        fetch(8'($urandom), 0, 1'b1, 1'b1);
        repeat (6) begin @(posedge clock); #1; end
        chk("halt_after_run_drop", 32'(state), 32'(ST_IDLE));

        // Single step, ack delayed 3 cycles
        pulse_step();
        fetch(8'h2E, 3, 1'b0, 1'b1);
        wait_state(ST_IDLE, 20);
        repeat (5) begin @(posedge clock); #1; end
        chk("step_stays_idle", 32'(state), 32'(ST_IDLE));
        chk("step_count", 32'(instr_count), 32'(model_cnt));

        // Acks in IDLE are ignored
        imem_ack = 1'b1; imem_data = 8'hFF;
        repeat (3) begin @(posedge clock); #1; end
        imem_ack = 1'b0;
        chk("idle_ack_ir", 32'(ir), 32'h2E);
        chk("idle_ack_state", 32'(state), 32'(ST_IDLE));

        // Step pulse mid-instruction is held and executed afterwards
        pulse_step();
        fetch(8'h97, 2, 1'b0, 1'b1);
        pulse_step();
        fetch(8'hD1, 0, 1'b0, 1'b1);
        wait_state(ST_IDLE, 20);
        repeat (5) begin @(posedge clock); #1; end
        chk("pending_step_idle", 32'(state), 32'(ST_IDLE));
        chk("pending_step_count", 32'(instr_count), 32'(model_cnt));

        // Fetch timeout into FAULT
        imem_ack = 1'b0;
        run = 1'b1;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin @(posedge clock); #1; n++; end
        n = 0;
        while (state === ST_FETCH && n < 40) begin @(posedge clock); #1; n++; end
        chk("fault_wait_cycles", 32'(n), 32'(WAIT_MAX));
        chk("fault_state", 32'(state), 32'(ST_FAULT));
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_req", 32'(imem_req), 32'd0);
        imem_ack = 1'b1; imem_data = 8'h00;
        repeat (4) begin @(posedge clock); #1; end
        imem_ack = 1'b0;
        chk("fault_absorbing", 32'(state), 32'(ST_FAULT));
        chk("fault_ir_held", 32'(ir), 32'hD1);
        chk("fault_sticky", 32'(fault), 32'd1);

        // Reset clears the fault
        run = 1'b0;
        reset = 1'b1;
        sb.delete();
        model_cnt = '0;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("fault_cleared", 32'(fault), 32'd0);
        chk("fault_reset_state", 32'(state), 32'(ST_IDLE));

        // Reset during MEM of a STORE aborts it
        run = 1'b1;
        fetch(8'h1B, 0, 1'b0, 1'b1);
        fetch(8'h85, 0, 1'b0, 1'b0);
        wait_state(ST_MEM, 10);
        chk("store_mem_write", 32'(mem_write), 32'd1);
        chk("pre_abort_count", 32'(instr_count), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_state", 32'(state), 32'(ST_IDLE));
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_count", 32'(instr_count), 32'd0);
        chk("abort_ir", 32'(ir), 32'd0);
        reset = 1'b0;
        run = 1'b0;
        model_cnt = '0;
        repeat (3) begin @(posedge clock); #1; end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle sequencer for the 8-bit, four-register core. Fetches one instruction byte over a req/ack handshake and holds it in IR.
- Steps the instruction through DECODE/EXEC/MEM/WB, asserting the datapath strobes (PC, register file, data memory, muxes) only in the correct cycle.
- Supports free-run, single-step and a fetch-timeout fault.
- Sits between instruction memory and the existing GPR/ALU/DataMemory datapath; replaces the one-instruction-per-clock control.

Parameters:
IMEM_WAIT_MAX, 15, cycles FETCH may wait for imem_ack before entering FAULT (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
run  in  1  level; 1 = continuous execution, 0 = halt at next instruction boundary
step  in  1  single-step request; rising edge executes one instruction while run=0
imem_req  out  1  instruction fetch request
imem_ack  in  1  instruction byte valid this cycle
imem_data  in  8  instruction byte
ir  out  8  registered instruction
ir_write  out  1  high in cycle IR captures imem_data
pc_write  out  1  PC update strobe
pc_src  out  1  0 = PC+1, 1 = PC+1+signext(ir[1:0])
reg_write  out  1  GPR write strobe
reg_dst  out  1  1 = dest ir[1:0], 0 = dest ir[3:2]
alu_src  out  1  1 = ALU B from signext(ir[1:0])
mem_read  out  1  data memory read
mem_write  out  1  data memory write
mem_to_reg  out  1  1 = writeback from memory
state  out  3  current state encoding
fault  out  1  sticky fetch-timeout flag
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (synchronous): state=IDLE, ir=0, fault=0, instr_count=0, wait counter=0, step_pending=0, step edge register=0. All strobes read 0 in the cycle after reset. Reset mid-instruction aborts the instruction; no partial strobes are issued.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7.
- Opcodes (ir[7:6]):
  - 00 = ADD rd=rs+rt
  - 01 = LOAD rt=M[rs+imm]
  - 10 = STORE M[rs+imm]=rt
  - 11 = BRANCH PC+=1+imm
- IDLE:
  - Go to FETCH if run=1 or step_pending=1; clear step_pending on that transition.
  - Step edge: step=1 with previous step=0. It sets step_pending only while run=0; an edge while run=1 is ignored.
- FETCH:
  - imem_req=1.
  - On imem_ack=1: ir<=imem_data, ir_write=1 in that same cycle, wait counter cleared, go to DECODE.
  - Otherwise increment the wait counter. When it reaches IMEM_WAIT_MAX with no ack: go to FAULT, fault<=1.
- DECODE: one cycle, no strobes, go to EXEC.
- EXEC:
  - ADD goes to WB; LOAD and STORE go to MEM.
  - BRANCH: pc_write=1, pc_src=1, retire.
- MEM:
  - LOAD: mem_read=1, go to WB.
  - STORE: mem_write=1, pc_write=1, pc_src=0, retire.
- WB: reg_write=1, pc_write=1, pc_src=0, retire.
  - ADD: reg_dst=1, mem_to_reg=0.
  - LOAD: reg_dst=0, mem_to_reg=1, mem_read held 1.
- Retire: instr_count+1, wrapping all-ones to 0. Next state is FETCH if run=1, else IDLE.
- Decode outputs:
  - reg_dst = ~ir[6], alu_src = ir[7]^ir[6], mem_to_reg = ir[6].
  - Driven only in DECODE/EXEC/MEM/WB; 0 in IDLE/FETCH/FAULT.
- Strobes pc_write, reg_write, mem_read, mem_write and ir_write are decoded from registered state (and imem_ack for ir_write). At most one pc_write per instruction.
- Latency after the ack cycle (to the retire cycle inclusive):
  - BRANCH 2
  - ADD 3
  - STORE 3
  - LOAD 4
- Boundary cases:
  - imem_ack outside FETCH is ignored.
  - run dropping mid-instruction completes the current instruction, then goes to IDLE.
  - FAULT is absorbing: all strobes 0, imem_req=0. Exit only via reset.
  - A step edge arriving during an instruction while run=0 is held pending and consumed at the next IDLE.

Test Plan:
- Reset, run=1, ack same cycle as req, imem_data=0x1B (ADD r1+r2->r3) -> ir_write in cycle0, DECODE, EXEC, WB with reg_write=1/reg_dst=1/pc_write=1; instr_count=1; back in FETCH.
- run=1, instruction 0x46 (LOAD) -> MEM with mem_read=1, WB with reg_write=1/mem_to_reg=1/reg_dst=0; 4 cycles after ack.
- Instructions 0x85 (STORE) then 0xC3 (BRANCH imm=-1) -> mem_write=1 only in MEM for STORE; BRANCH gives pc_write=1/pc_src=1 in EXEC; no reg_write in either.
- run=0, single step pulse, ack after 3 cycles -> exactly one instruction retires, state returns to IDLE, instr_count increments by 1; a second pulse mid-instruction is executed afterwards.
- run=1, imem_ack held low -> FAULT (state=7) after 15 waiting cycles, fault=1, imem_req=0; later acks ignored until reset clears fault.
- Assert reset during MEM of a STORE -> next cycle state=IDLE, mem_write=0, instr_count=0, ir=0.
